sha2_msg_scheduler_param: RTL and testbench
===========================================

Name: sha2_msg_scheduler_param

Overview:
Parametrised SHA-2 message-schedule generator that takes one padded message block and streams the expanded schedule W[0..ROUNDS-1] as LANES words per beat.
- Supports the SHA-256 (32-bit word, 64 rounds) and SHA-512 (64-bit word, 80 rounds) variants.
- Adds downstream ready/valid backpressure, zero-bubble back-to-back blocks and a synchronous abort.
- Sits between the padding/block buffer and the compression round pipeline.

Parameters:
WORD_W, 32, word width; 32 selects SHA-256 sigma constants, 64 selects SHA-512 constants.
ROUNDS, 64, schedule length; must be 64 when WORD_W=32 and 80 when WORD_W=64.
LANES, 8, words per output beat; one of 1, 2, 4, 8, 16; must divide ROUNDS.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
input_valid  input  1  block_in is valid this cycle
block_in  input  16*WORD_W  message block; W0 in the MSBs, W15 in the LSBs
scheduler_ready  output  1  block accepted when input_valid && scheduler_ready
abort  input  1  synchronous flush of the current block
scheduler_valid  output  1  w_out holds a valid beat
out_ready  input  1  downstream accepts a beat when scheduler_valid && out_ready
w_out  output  LANES*WORD_W  W[t..t+LANES-1], lane 0 (W[t]) in the MSBs
beat_idx  output  clog2(ROUNDS/LANES)  index of the current beat; t = beat_idx*LANES
last  output  1  high with the final beat (beat_idx == ROUNDS/LANES-1)

Behaviour:
- Reset values: scheduler_valid=0, w_out=0, beat_idx=0, last=0, FSM=IDLE, window=0. scheduler_ready=1 as soon as reset is released.
- FSM has two states, IDLE and RUN.
  - IDLE: scheduler_ready=1 and scheduler_valid=0. On accept, load the 16-word window from block_in, set beat_idx=0, go to RUN.
  - RUN: scheduler_valid=1; w_out shows the window's top LANES words.
- Latency: beat 0 appears the cycle after accept.
- Beat handshake in RUN with out_ready=1:
  - The window shifts by LANES words.
  - LANES new words are appended, each W[i] = s1(W[i-2]) + W[i-7] + s0(W[i-15]) + W[i-16] mod 2^WORD_W.
  - The new-word computation is chained within the beat, so later lanes use earlier lanes' results.
  - beat_idx increments.
- Backpressure: while scheduler_valid && !out_ready, w_out, beat_idx and last are held bit-stable.
- Sigma functions:
  - WORD_W=32: s0 = ROTR7^ROTR18^SHR3, s1 = ROTR17^ROTR19^SHR10.
  - WORD_W=64: s0 = ROTR1^ROTR8^SHR7, s1 = ROTR19^ROTR61^SHR6.
- Last beat consumed:
  - If input_valid is high the same cycle, the new block is accepted and its beat 0 appears next cycle (zero bubble).
  - In that cycle scheduler_ready = (state==RUN && last && out_ready); this combinational path is permitted.
  - Otherwise the FSM returns to IDLE.
- input_valid while scheduler_ready=0 is ignored; the block is not captured.
- abort (RUN or IDLE): next cycle FSM=IDLE, scheduler_valid=0, beat_idx=0. abort has priority over a simultaneous accept or beat handshake.
- Reset mid-block: immediately returns all outputs to their reset values.
- No internal storage beyond the 16-word window and the beat counter.

Decomposition:
- Package sha2_sched_pkg holds:
  - rotate/shift constants for both variants;
  - sigma0/sigma1 functions parametrised by WORD_W;
  - the state enum (IDLE, RUN);
  - an elaboration check that ROUNDS%LANES==0 and that the (WORD_W, ROUNDS) pair is legal.
- One combinational sub-module, sha2_schedule_expand, produces the LANES next words from the 16-word window.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> scheduler_valid=0, w_out=0, beat_idx=0 asynchronously; scheduler_ready=1 after release.
- SHA-256 "abc" (WORD_W=32, LANES=8, block 0x61626380 0..0 0x00000018), out_ready=1 -> 8 consecutive beats:
  - beat0 = 61626380 followed by seven 00000000;
  - beat1 ends 00000018;
  - beat2 starts 61626380 000f0000 7da86405 600003c6;
  - last=1 only on beat7; scheduler_ready=1 next cycle.
- Backpressure: same vector, out_ready=0 for 3 cycles at beat2 -> w_out and beat_idx=2 held stable; the sequence resumes unchanged, still 8 distinct beats.
- Back-to-back: second block presented with input_valid during the last-beat handshake -> accepted; its beat0 arrives the next cycle; 16 contiguous valid cycles.
- Abort: abort=1 at beat4 -> next cycle scheduler_valid=0 and scheduler_ready=1; a new block restarts at beat_idx=0 with correct words.
- SHA-512 (WORD_W=64, ROUNDS=80, LANES=4), "abc" block W0=0x6162638000000000, W15=0x18 -> 20 beats:
  - beat4 starts 6162638000000000 00030000000000c0;
  - last on beat19.

Source files
------------

// File: rtl/sha2_sched_pkg.sv
// Shared constants, sigma helpers and state encoding for the SHA-2 message scheduler.
package sha2_sched_pkg;

  // SHA-256 rotate/shift amounts
  localparam int unsigned S256_S0_R1 = 7;
  localparam int unsigned S256_S0_R2 = 18;
  localparam int unsigned S256_S0_SH = 3;
  localparam int unsigned S256_S1_R1 = 17;
  localparam int unsigned S256_S1_R2 = 19;
  localparam int unsigned S256_S1_SH = 10;

  // SHA-512 rotate/shift amounts
  localparam int unsigned S512_S0_R1 = 1;
  localparam int unsigned S512_S0_R2 = 8;
  localparam int unsigned S512_S0_SH = 7;
  localparam int unsigned S512_S1_R1 = 19;
  localparam int unsigned S512_S1_R2 = 61;
  localparam int unsigned S512_S1_SH = 6;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } sched_state_e;

  // Words are carried in a 64-bit container; 32-bit words live in the low half.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n,
                                       input int unsigned word_w);
    logic [63:0] y;
    if (word_w == 32) begin
      y = {32'h0, (x[31:0] >> n) | (x[31:0] << (32 - n))};
    end else begin
      y = (x >> n) | (x << (64 - n));
    end
    return y;
  endfunction

  function automatic logic [63:0] sigma0(input logic [63:0] x, input int unsigned word_w);
    logic [63:0] y;
    if (word_w == 32) begin
      y = rotr(x, S256_S0_R1, 32) ^ rotr(x, S256_S0_R2, 32) ^ ({32'h0, x[31:0]} >> S256_S0_SH);
    end else begin
      y = rotr(x, S512_S0_R1, 64) ^ rotr(x, S512_S0_R2, 64) ^ (x >> S512_S0_SH);
    end
    return y;
  endfunction

  function automatic logic [63:0] sigma1(input logic [63:0] x, input int unsigned word_w);
    logic [63:0] y;
    if (word_w == 32) begin
      y = rotr(x, S256_S1_R1, 32) ^ rotr(x, S256_S1_R2, 32) ^ ({32'h0, x[31:0]} >> S256_S1_SH);
    end else begin
      y = rotr(x, S512_S1_R1, 64) ^ rotr(x, S512_S1_R2, 64) ^ (x >> S512_S1_SH);
    end
    return y;
  endfunction

  // Legal combinations: (32,64) or (64,80), LANES a power of two up to 16 dividing ROUNDS.
  function automatic bit params_legal(input int unsigned word_w, input int unsigned rounds,
                                      input int unsigned lanes);
    bit pair_ok;
    bit lanes_ok;
    pair_ok  = ((word_w == 32) && (rounds == 64)) || ((word_w == 64) && (rounds == 80));
    lanes_ok = (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
    return pair_ok && lanes_ok && ((rounds % lanes) == 0);
  endfunction

endpackage

// File: rtl/sha2_schedule_expand.sv
// Combinational expansion: derives the next LANES schedule words from the 16-word window.
module sha2_schedule_expand
  import sha2_sched_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned LANES  = 8
) (
  input  logic [16*WORD_W-1:0]    window,
  output logic [LANES*WORD_W-1:0] next_words
);

  // ext[0..15] is the window (oldest first); ext[16+j] are the new words.
  logic [WORD_W-1:0] ext [16+LANES];

  // Chained recurrence: later lanes consume earlier lanes' fresh words.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      ext[i] = window[(15-i)*WORD_W +: WORD_W];
    end
    for (int j = 0; j < LANES; j++) begin
      ext[16+j] = WORD_W'(sigma1(64'(ext[14+j]), WORD_W)) + ext[9+j]
                + WORD_W'(sigma0(64'(ext[1+j]), WORD_W)) + ext[j];
    end
    next_words = '0;
    for (int j = 0; j < LANES; j++) begin
      next_words[(LANES-1-j)*WORD_W +: WORD_W] = ext[16+j];
    end
  end

endmodule

// File: rtl/sha2_msg_scheduler_param.sv
// SHA-2 message-schedule generator: loads one block, streams W[0..ROUNDS-1] LANES words per beat.
module sha2_msg_scheduler_param
  import sha2_sched_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned LANES  = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              input_valid,
  input  logic [16*WORD_W-1:0]              block_in,
  output logic                              scheduler_ready,
  input  logic                              abort,
  output logic                              scheduler_valid,
  input  logic                              out_ready,
  output logic [LANES*WORD_W-1:0]           w_out,
  output logic [$clog2(ROUNDS/LANES)-1:0]   beat_idx,
  output logic                              last
);

  localparam int unsigned Beats = ROUNDS / LANES;
  localparam int unsigned BeatW = $clog2(Beats);
  localparam int unsigned WinW  = 16 * WORD_W;
  localparam int unsigned OutW  = LANES * WORD_W;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

  if (!params_legal(WORD_W, ROUNDS, LANES)) begin : g_param_check
    $error("sha2_msg_scheduler_param: illegal WORD_W/ROUNDS/LANES combination");
  end

  sched_state_e     state_q;
  logic [WinW-1:0]  window_q;
  logic [BeatW-1:0] beat_q;
  logic [OutW-1:0]  next_words;
  logic [WinW-1:0]  window_shift;
  logic             accept;
  logic             beat_fire;

  sha2_schedule_expand #(
    .WORD_W (WORD_W),
    .LANES  (LANES)
  ) u_expand (
    .window     (window_q),
    .next_words (next_words)
  );

  // With 16 lanes the whole window is replaced each beat.
  if (LANES == 16) begin : g_shift_full
    assign window_shift = next_words;
  end else begin : g_shift_part
    assign window_shift = {window_q[WinW-OutW-1:0], next_words};
  end

  assign scheduler_valid = (state_q == StRun);
  assign last            = (state_q == StRun) && (beat_q == LastBeat);
  // Ready also rises during the final handshake so the next block follows with no bubble.
  assign scheduler_ready = (state_q == StIdle) || (last && out_ready);
  assign accept          = input_valid && scheduler_ready;
  assign beat_fire       = scheduler_valid && out_ready;
  assign w_out           = window_q[WinW-1 -: OutW];
  assign beat_idx        = beat_q;

  // FSM, window and beat counter; abort outranks both accept and beat handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      window_q <= '0;
      beat_q   <= '0;
    end else if (abort) begin
      state_q <= StIdle;
      beat_q  <= '0;
    end else if (accept) begin
      state_q  <= StRun;
      window_q <= block_in;
      beat_q   <= '0;
    end else if (beat_fire) begin
      if (last) begin
        state_q <= StIdle;
        beat_q  <= '0;
      end else begin
        window_q <= window_shift;
        beat_q   <= beat_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sha2_msg_scheduler_param.sv
// Self-checking bench: SHA-256 (LANES=8) and SHA-512 (LANES=4) instances with a scoreboard.
module tb_sha2_msg_scheduler_param;

  typedef struct {
    logic [255:0] w;
    logic [7:0]   idx;
    logic         last;
  } exp_t;

  logic clk;
  logic rst_n;

  logic         iv32, rdy32, ab32, v32, ordy32, last32;
  logic [511:0] blk32;
  logic [255:0] w32;
  logic [2:0]   bidx32;

  logic          iv64, rdy64, ab64, v64, ordy64, last64;
  logic [1023:0] blk64;
  logic [255:0]  w64;
  logic [4:0]    bidx64;

  exp_t sb32[$];
  exp_t sb64[$];
  int   n_assert;
  int   n_fail;

  sha2_msg_scheduler_param #(.WORD_W(32), .ROUNDS(64), .LANES(8)) dut32 (
    .clk             (clk),
    .rst_n           (rst_n),
    .input_valid     (iv32),
    .block_in        (blk32),
    .scheduler_ready (rdy32),
    .abort           (ab32),
    .scheduler_valid (v32),
    .out_ready       (ordy32),
    .w_out           (w32),
    .beat_idx        (bidx32),
    .last            (last32)
  );

  sha2_msg_scheduler_param #(.WORD_W(64), .ROUNDS(80), .LANES(4)) dut64 (
    .clk             (clk),
    .rst_n           (rst_n),
    .input_valid     (iv64),
    .block_in        (blk64),
    .scheduler_ready (rdy64),
    .abort           (ab64),
    .scheduler_valid (v64),
    .out_ready       (ordy64),
    .w_out           (w64),
    .beat_idx        (bidx64),
    .last            (last64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference schedule model
  function automatic logic [63:0] rr(input logic [63:0] x, input int n, input int w);
    logic [63:0] m;
    m = (w == 32) ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
    return ((x >> n) | (x << (w - n))) & m;
  endfunction

  function automatic logic [63:0] ms0(input logic [63:0] x, input int w);
    if (w == 32) return rr(x, 7, w) ^ rr(x, 18, w) ^ (x >> 3);
    return rr(x, 1, w) ^ rr(x, 8, w) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] ms1(input logic [63:0] x, input int w);
    if (w == 32) return rr(x, 17, w) ^ rr(x, 19, w) ^ (x >> 10);
    return rr(x, 19, w) ^ rr(x, 61, w) ^ (x >> 6);
  endfunction

  function automatic logic [255:0] model_beat(input logic [1023:0] blk, input int w,
                                              input int lanes, input int b);
    logic [63:0]  m [80];
    logic [63:0]  mask;
    logic [255:0] res;
    mask = (w == 32) ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
    for (int i = 0; i < 16; i++) begin
      if (w == 32) m[i] = {32'h0, blk[(15-i)*32 +: 32]};
      else         m[i] = blk[(15-i)*64 +: 64];
    end
    for (int t = 16; t < 80; t++) begin
      m[t] = (ms1(m[t-2], w) + m[t-7] + ms0(m[t-15], w) + m[t-16]) & mask;
    end
    res = '0;
    for (int k = 0; k < lanes; k++) begin
      res = (res << w) | 256'(m[b*lanes+k]);
    end
    return res;
  endfunction

  task automatic push32(input logic [511:0] blk);
    exp_t e;
    for (int b = 0; b < 8; b++) begin
      e.w    = model_beat({512'h0, blk}, 32, 8, b);
      e.idx  = 8'(b);
      e.last = (b == 7);
      sb32.push_back(e);
    end
  endtask

  task automatic push64(input logic [1023:0] blk);
    exp_t e;
    for (int b = 0; b < 20; b++) begin
      e.w    = model_beat(blk, 64, 4, b);
      e.idx  = 8'(b);
      e.last = (b == 19);
      sb64.push_back(e);
    end
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample both DUTs away from the edge, then advance one clock.
  task automatic cycle();
    exp_t e;
    #1;
    if (v32 && ordy32 && !ab32) begin
      chk("sb32_has_entry", 256'(sb32.size() != 0), 256'(1));
      if (sb32.size() != 0) begin
        e = sb32.pop_front();
        chk($sformatf("w32_beat%0d", e.idx), w32, e.w);
        chk($sformatf("idx32_beat%0d", e.idx), 256'(bidx32), 256'(e.idx));
        chk($sformatf("last32_beat%0d", e.idx), 256'(last32), 256'(e.last));
      end
    end
    if (v64 && ordy64 && !ab64) begin
      chk("sb64_has_entry", 256'(sb64.size() != 0), 256'(1));
      if (sb64.size() != 0) begin
        e = sb64.pop_front();
        chk($sformatf("w64_beat%0d", e.idx), w64, e.w);
        chk($sformatf("idx64_beat%0d", e.idx), 256'(bidx64), 256'(e.idx));
        chk($sformatf("last64_beat%0d", e.idx), 256'(last64), 256'(e.last));
      end
    end
    if (iv32 && rdy32 && !ab32) push32(blk32);
    if (iv64 && rdy64 && !ab64) push64(blk64);
    @(posedge clk);
    #1;
  endtask

  task automatic drain32(input string tag);
    for (int i = 0; i < 40 && sb32.size() != 0; i++) cycle();
    chk(tag, 256'(sb32.size()), 256'(0));
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  initial begin
    logic [511:0]  abc32;
    logic [1023:0] abc64;
    logic [255:0]  expb2;
    int            cnt;
    bit            sent;

    abc32 = {32'h61626380, 448'h0, 32'h0000_0018};
    abc64 = {64'h6162_6380_0000_0000, 896'h0, 64'h18};
    n_assert = 0;
    n_fail   = 0;
    rst_n  = 1'b0;
    iv32   = 1'b0; blk32 = '0; ab32 = 1'b0; ordy32 = 1'b1;
    iv64   = 1'b0; blk64 = '0; ab64 = 1'b0; ordy64 = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_valid32", 256'(v32), 256'(0));
    chk("rst_wout32", w32, 256'(0));
    chk("rst_idx32", 256'(bidx32), 256'(0));
    chk("rst_last32", 256'(last32), 256'(0));
    chk("rst_ready32", 256'(rdy32), 256'(1));
    chk("rst_valid64", 256'(v64), 256'(0));
    chk("rst_ready64", 256'(rdy64), 256'(1));

    // SHA-256 "abc", no backpressure
    blk32 = abc32; iv32 = 1'b1;
    cycle();
    iv32 = 1'b0;
    for (int i = 0; i < 20 && sb32.size() != 0; i++) begin
      if (v32 && bidx32 == 3'd0) chk("abc_beat0", w32, {32'h61626380, 224'h0});
      if (v32 && bidx32 == 3'd1) chk("abc_beat1_tail", 256'(w32[31:0]), 256'(32'h18));
      if (v32 && bidx32 == 3'd2)
        chk("abc_beat2_head", 256'(w32[255:128]),
            256'({32'h61626380, 32'h000f0000, 32'h7da86405, 32'h600003c6}));
      cycle();
    end
    chk("abc_drained", 256'(sb32.size()), 256'(0));
    chk("abc_ready_after_last", 256'(rdy32), 256'(1));
    chk("abc_valid_after_last", 256'(v32), 256'(0));

    // Backpressure at beat 2
    blk32 = abc32; iv32 = 1'b1;
    cycle();
    iv32 = 1'b0;
    for (int i = 0; i < 10 && !(v32 && bidx32 == 3'd2); i++) cycle();
    chk("bp_reach_beat2", 256'(bidx32), 256'(2));
    expb2 = model_beat({512'h0, abc32}, 32, 8, 2);
    ordy32 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_hold_w", w32, expb2);
      chk("bp_hold_idx", 256'(bidx32), 256'(2));
      chk("bp_hold_valid", 256'(v32), 256'(1));
    end
    ordy32 = 1'b1;
    drain32("bp_drained");

    // Back-to-back blocks: second offered during the last-beat handshake
    blk32 = abc32; iv32 = 1'b1;
    cycle();
    iv32 = 1'b0;
    cnt  = 0;
    sent = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!v32) break;
      cnt++;
      if (last32 && !sent) begin
        iv32 = 1'b1; blk32 = rand_block(); sent = 1'b1;
      end else begin
        iv32 = 1'b0;
      end
      cycle();
    end
    iv32 = 1'b0;
    chk("b2b_contiguous_valid", 256'(cnt), 256'(16));
    chk("b2b_drained", 256'(sb32.size()), 256'(0));

    // Abort at beat 4, then abort beating a simultaneous accept
    blk32 = rand_block(); iv32 = 1'b1;
    cycle();
    iv32 = 1'b0;
    for (int i = 0; i < 10 && !(v32 && bidx32 == 3'd4); i++) cycle();
    chk("abort_reach_beat4", 256'(bidx32), 256'(4));
    ab32 = 1'b1; ordy32 = 1'b0;
    cycle();
    ab32 = 1'b0; ordy32 = 1'b1;
    sb32.delete();
    chk("abort_valid", 256'(v32), 256'(0));
    chk("abort_ready", 256'(rdy32), 256'(1));
    chk("abort_idx", 256'(bidx32), 256'(0));
    ab32 = 1'b1; iv32 = 1'b1; blk32 = rand_block();
    cycle();
    ab32 = 1'b0; iv32 = 1'b0;
    chk("abort_beats_accept", 256'(v32), 256'(0));

    // Restart after abort; input_valid during busy beats must be ignored
    blk32 = rand_block(); iv32 = 1'b1;
    cycle();
    iv32  = 1'b0;
    blk32 = rand_block();
    for (int i = 0; i < 40 && sb32.size() != 0; i++) begin
      iv32 = v32 && (bidx32 >= 3'd1) && (bidx32 <= 3'd3);
      cycle();
    end
    iv32 = 1'b0;
    chk("restart_drained", 256'(sb32.size()), 256'(0));
    chk("busy_input_ignored", 256'(v32), 256'(0));

    // Asynchronous reset mid-block
    blk32 = rand_block(); iv32 = 1'b1;
    cycle();
    iv32 = 1'b0;
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 256'(v32), 256'(0));
    chk("midrst_wout", w32, 256'(0));
    chk("midrst_idx", 256'(bidx32), 256'(0));
    chk("midrst_last", 256'(last32), 256'(0));
    sb32.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_ready_after", 256'(rdy32), 256'(1));

    // SHA-512 "abc"
    blk64 = abc64; iv64 = 1'b1;
    cycle();
    iv64 = 1'b0;
    for (int i = 0; i < 40 && sb64.size() != 0; i++) begin
      if (v64 && bidx64 == 5'd4)
        chk("s512_beat4_head", 256'(w64[255:128]),
            256'({64'h6162_6380_0000_0000, 64'h0003_0000_0000_00c0}));
      cycle();
    end
    chk("s512_drained", 256'(sb64.size()), 256'(0));
    chk("s512_ready_after_last", 256'(rdy64), 256'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
